normalize_round_pipe: RTL and testbench
=======================================

// Module: normalize_round_pipe
// PURPOSE
//  Two-stage pipelined normalise-and-round stage for the FP multiplier datapath. Takes the raw
//  2*MANT_W-bit significand product, biased exponent sum and sign, and normalises to one hidden bit.
//  Rounds with one of six modes and returns MANT_W-bit mantissa (hidden bit at MSB), exponent, inexact.
//  Sits between the significand multiplier and exception/packing logic; valid/ready on both sides.
// PARAMETERS
//  MANT_W   24   significand width incl. hidden bit; product width PW = 2*MANT_W
//  EXP_W    10   exponent width, two's complement; wraps modulo 2^EXP_W (range check is downstream)
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        upstream presents P/exp_in/sign_in/round_mode
//  in_ready     out  1        block accepts this cycle (transfer = in_valid & in_ready)
//  P            in   PW       unsigned significand product
//  exp_in       in   EXP_W    exponent before normalisation
//  sign_in      in   1        result sign
//  round_mode   in   3        0 near-even, 1 zero, 2 +inf, 3 -inf, 4 near-away, 5 away-zero; 6,7 = 0
//  out_valid    out  1        result valid
//  out_ready    in   1        downstream accepts (transfer = out_valid & out_ready)
//  mant_out     out  MANT_W   rounded mantissa, hidden bit at [MANT_W-1]
//  exp_out      out  EXP_W    normalised, round-adjusted exponent
//  sign_out     out  1        sign_in delayed
//  inexact      out  1        guard | sticky of the normalised value
// BEHAVIOUR
//  - Reset: every output register and valid flag 0 immediately on rst_n low; in_ready = 1 after reset.
//    Reset mid-operation drops all in-flight items; no partial result ever appears.
//  - Stage 1 (normalise), registered:
//    P[PW-1]=1: m=P[PW-1:MANT_W], G=P[MANT_W-1], S=|P[MANT_W-2:0], e=exp_in+1
//    else:      m=P[PW-2:MANT_W-1], G=P[MANT_W-2], S=|P[MANT_W-3:0], e=exp_in
//  - Stage 2 (round), registered: up = f(mode,G,S,m[0],sign):
//    near-even G&(S|m[0]); zero 0; +inf (G|S)&!sign; -inf (G|S)&sign; near-away G; away-zero G|S.
//    m+up carry-out (m all ones) -> mant_out = 1<<(MANT_W-1), exp_out = e+1; else exp_out = e.
//    inexact = G|S regardless of mode.
//  - Latency 2 cycles input transfer -> out_valid with out_ready held high; throughput 1/cycle.
//  - Handshake: per-stage valid bits v1,v2. Stage 2 loads when !v2 | out_ready; stage 1 loads when
//    !v1 | stage 2 loads. in_ready = !v1 | !v2 | out_ready (combinational, no in_valid dependency).
//  - Stall: out_valid & !out_ready -> all outputs held stable; at most 2 items buffered, none lost.
//  - Simultaneous accept and emit in same cycle with both stages full is legal (full-rate flow).
//  - P = 0: mant_out 0, exp_out = exp_in, inexact 0 (zero detect is downstream).
//  - Bubbles: empty stage's data registers may hold stale values; only valid qualifies data.
// CONFIGURATION
//  NORM_LZC_EN defined: stage 1 adds leading-zero count over P[PW-2:0] when P[PW-1]=0 (subnormal
//    operands); P shifted left so leading one lands at PW-2, e = exp_in - lzc, then rules above.
//    P=0 handled as stated. Latency unchanged (LZC+shift within stage 1).
//  NORM_LZC_EN undefined: 1-bit normalisation only; P[PW-1]=0 always takes the else branch even if
//    P[PW-2]=0 (mantissa returned unnormalised).
// TESTING (MANT_W=24, EXP_W=10, out_ready=1 unless stated)
//  1 P=48'h8000_0000_0000, exp_in=5, mode 0 -> mant_out 24'h800000, exp_out 6, inexact 0, 2 cycles later
//  2 P=48'h4000_0000_0000, exp_in=5 -> mant_out 24'h800000, exp_out 5, inexact 0
//  3 P=48'h8000_0080_0000, exp_in=5: mode 0 -> 24'h800000 exp 6 inexact 1; mode 4 -> 24'h800001
//  4 P=48'hFFFF_FF80_0000, exp_in=5: mode 0 -> 24'h800000, exp 7; mode 1 -> 24'hFFFFFF, exp 6; inexact 1
//  5 out_ready=0, 3 back-to-back inputs -> 2 accepted, in_ready 0, outputs stable; out_ready=1 -> in order
//  6 P=48'h0000_0100_0000, exp_in=30: LZC_EN -> 24'h800000, exp 8; else -> 24'h000002, exp 30;
//    rst_n pulse with both stages full -> out_valid 0 same cycle, no stale output after release

Source files
------------

// File: rtl/normalize_round_pipe_if.sv
// Handshake/data bundle for normalize_round_pipe: upstream product side and downstream result side.
// slave = the pipe itself, master = whoever drives the product and consumes the result.
interface normalize_round_pipe_if #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned EXP_W  = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*MANT_W-1:0]   p;
    logic [EXP_W-1:0]      exp_in;
    logic                  sign_in;
    logic [2:0]            round_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [MANT_W-1:0]     mant_out;
    logic [EXP_W-1:0]      exp_out;
    logic                  sign_out;
    logic                  inexact;

    modport master (
        output in_valid, p, exp_in, sign_in, round_mode, out_ready,
        input  in_ready, out_valid, mant_out, exp_out, sign_out, inexact
    );

    modport slave (
        input  in_valid, p, exp_in, sign_in, round_mode, out_ready,
        output in_ready, out_valid, mant_out, exp_out, sign_out, inexact
    );
endinterface

// File: rtl/normalize_round_pipe.sv
// Two-stage normalise (stage 1) and round (stage 2) pipe for the FP multiplier significand.
// Optional NORM_LZC_EN: full leading-zero normalisation of subnormal products in stage 1.
module normalize_round_pipe #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned EXP_W  = 10
) (
    input logic                   clk,
    input logic                   rst_n,
    normalize_round_pipe_if.slave bus
);
    localparam int unsigned PW  = 2 * MANT_W;
    localparam int unsigned LZW = $clog2(PW);

    logic [PW-1:0]     pn;
    logic [EXP_W-1:0]  en;

`ifdef NORM_LZC_EN
    logic [LZW-1:0] lzc;
    logic           found;

    // P = 0 leaves lzc at 0 so the exponent passes through untouched.
    always_comb begin
        lzc   = '0;
        found = 1'b0;
        for (int i = PW - 2; i >= 0; i--) begin
            if (!found && bus.p[i]) begin
                lzc   = LZW'(PW - 2 - i);
                found = 1'b1;
            end
        end
        pn = bus.p;
        en = bus.exp_in;
        if (!bus.p[PW-1]) begin
            pn = bus.p << lzc;
            en = bus.exp_in - EXP_W'(lzc);
        end
    end
`else
    assign pn = bus.p;
    assign en = bus.exp_in;
`endif

    logic [MANT_W-1:0] m1_d, m1_q;
    logic              g1_d, g1_q, s1_d, s1_q;
    logic [EXP_W-1:0]  e1_d, e1_q;
    logic              sign1_q;
    logic [2:0]        mode1_q;
    logic              v1_q;

    always_comb begin
        if (pn[PW-1]) begin
            m1_d = pn[PW-1:MANT_W];
            g1_d = pn[MANT_W-1];
            s1_d = |pn[MANT_W-2:0];
            e1_d = en + EXP_W'(1);
        end else begin
            m1_d = pn[PW-2:MANT_W-1];
            g1_d = pn[MANT_W-2];
            s1_d = |pn[MANT_W-3:0];
            e1_d = en;
        end
    end

    logic              up;
    logic [MANT_W:0]   sum;
    logic [MANT_W-1:0] mant_d, mant_q;
    logic [EXP_W-1:0]  exp_d, exp_q;
    logic              sign_q, inexact_q, v2_q;

    always_comb begin
        case (mode1_q)
            3'd1:    up = 1'b0;
            3'd2:    up = (g1_q | s1_q) & ~sign1_q;
            3'd3:    up = (g1_q | s1_q) & sign1_q;
            3'd4:    up = g1_q;
            3'd5:    up = g1_q | s1_q;
            default: up = g1_q & (s1_q | m1_q[0]);
        endcase
        sum = {1'b0, m1_q} + {{MANT_W{1'b0}}, up};
        // Carry-out only when m was all ones: result is exactly 1.0 at the next binade.
        if (sum[MANT_W]) begin
            mant_d = {1'b1, {(MANT_W-1){1'b0}}};
            exp_d  = e1_q + EXP_W'(1);
        end else begin
            mant_d = sum[MANT_W-1:0];
            exp_d  = e1_q;
        end
    end

    logic ld2, ld1;
    assign ld2          = ~v2_q | bus.out_ready;
    assign ld1          = ~v1_q | ld2;
    assign bus.in_ready = ld1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            m1_q      <= '0;
            g1_q      <= 1'b0;
            s1_q      <= 1'b0;
            e1_q      <= '0;
            sign1_q   <= 1'b0;
            mode1_q   <= '0;
            v2_q      <= 1'b0;
            mant_q    <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            if (ld1) begin
                v1_q    <= bus.in_valid;
                m1_q    <= m1_d;
                g1_q    <= g1_d;
                s1_q    <= s1_d;
                e1_q    <= e1_d;
                sign1_q <= bus.sign_in;
                mode1_q <= bus.round_mode;
            end
            if (ld2) begin
                v2_q      <= v1_q;
                mant_q    <= mant_d;
                exp_q     <= exp_d;
                sign_q    <= sign1_q;
                inexact_q <= g1_q | s1_q;
            end
        end
    end

    assign bus.out_valid = v2_q;
    assign bus.mant_out  = mant_q;
    assign bus.exp_out   = exp_q;
    assign bus.sign_out  = sign_q;
    assign bus.inexact   = inexact_q;
endmodule

// File: tb/tb_normalize_round_pipe.sv
// Self-checking bench for normalize_round_pipe (MANT_W=24, EXP_W=10): directed cases plus
// randomized traffic against an arithmetic reference model and an in-order scoreboard.
module tb_normalize_round_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    normalize_round_pipe_if #(.MANT_W(24), .EXP_W(10)) bus ();

    normalize_round_pipe #(.MANT_W(24), .EXP_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [23:0] mant;
        logic [9:0]  exp;
        logic        sign;
        logic        inx;
    } res_t;

    res_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        last_in_xfer;
    logic [23:0] last_mant;
    logic [9:0]  last_exp;
    logic        last_inx;

    // Rounding from the value's remainder relative to one half ulp, no G/S bit picking.
    function automatic res_t ref_model(input logic [47:0] p, input logic [9:0] e_in,
                                       input logic s, input logic [2:0] mode);
        res_t              r;
        longint unsigned   pv, m, rem, half;
        int                sh, e;
        logic              up, inx;
        pv = 64'(p);
        e  = int'(e_in);
        if (pv[47]) begin
            sh = 24;
            e  = e + 1;
        end else begin
`ifdef NORM_LZC_EN
            if (pv != 0) begin
                while (!pv[46]) begin
                    pv = pv << 1;
                    e  = e - 1;
                end
            end
`endif
            sh = 23;
        end
        m    = pv >> sh;
        rem  = pv & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
        case (mode)
            3'd1:    up = 1'b0;
            3'd2:    up = inx && !s;
            3'd3:    up = inx && s;
            3'd4:    up = (rem >= half);
            3'd5:    up = inx;
            default: up = (rem > half) || ((rem == half) && m[0]);
        endcase
        m = m + (up ? 64'd1 : 64'd0);
        if (m == (64'd1 << 24)) begin
            m = 64'd1 << 23;
            e = e + 1;
        end
        r.mant = 24'(m);
        r.exp  = 10'(e);
        r.sign = s;
        r.inx  = inx;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One cycle: sample handshakes at negedge, then advance past the next posedge.
    task automatic tick();
        res_t e;
        @(negedge clk);
        last_in_xfer = bus.in_valid && bus.in_ready;
        if (last_in_xfer)
            q.push_back(ref_model(bus.p, bus.exp_in, bus.sign_in, bus.round_mode));
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                e = q.pop_front();
                chk("sb_mant", 64'(bus.mant_out), 64'(e.mant));
                chk("sb_exp", 64'(bus.exp_out), 64'(e.exp));
                chk("sb_sign", 64'(bus.sign_out), 64'(e.sign));
                chk("sb_inexact", 64'(bus.inexact), 64'(e.inx));
                last_mant = bus.mant_out;
                last_exp  = bus.exp_out;
                last_inx  = bus.inexact;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [47:0] p, input logic [9:0] e, input logic s,
                            input logic [2:0] mode);
        int n = 0;
        bus.in_valid   = 1'b1;
        bus.p          = p;
        bus.exp_in     = e;
        bus.sign_in    = s;
        bus.round_mode = mode;
        do begin
            tick();
            n++;
        end while (!last_in_xfer && n < 20);
        if (!last_in_xfer) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] r;
        logic [47:0] pr;
        int          n;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.p          = '0;
        bus.exp_in     = '0;
        bus.sign_in    = 1'b0;
        bus.round_mode = '0;
        bus.out_ready  = 1'b1;
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mant", 64'(bus.mant_out), 64'd0);
        chk("rst_exp", 64'(bus.exp_out), 64'd0);
        chk("rst_inexact", 64'(bus.inexact), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Exact power of two with top bit set; also checks two-cycle latency.
        send_one(48'h8000_0000_0000, 10'd5, 1'b0, 3'd0);
        chk("t1_lat1", 64'(bus.out_valid), 64'd0);
        tick();
        chk("t1_lat2", 64'(bus.out_valid), 64'd1);
        drain();
        chk("t1_mant", 64'(last_mant), 64'h800000);
        chk("t1_exp", 64'(last_exp), 64'd6);
        chk("t1_inx", 64'(last_inx), 64'd0);

        send_one(48'h4000_0000_0000, 10'd5, 1'b0, 3'd0);
        drain();
        chk("t2_mant", 64'(last_mant), 64'h800000);
        chk("t2_exp", 64'(last_exp), 64'd5);
        chk("t2_inx", 64'(last_inx), 64'd0);

        send_one(48'h8000_0080_0000, 10'd5, 1'b0, 3'd0);
        drain();
        chk("t3_even_mant", 64'(last_mant), 64'h800000);
        chk("t3_even_exp", 64'(last_exp), 64'd6);
        chk("t3_even_inx", 64'(last_inx), 64'd1);
        send_one(48'h8000_0080_0000, 10'd5, 1'b0, 3'd4);
        drain();
        chk("t3_away_mant", 64'(last_mant), 64'h800001);

        send_one(48'hFFFF_FF80_0000, 10'd5, 1'b0, 3'd0);
        drain();
        chk("t4_carry_mant", 64'(last_mant), 64'h800000);
        chk("t4_carry_exp", 64'(last_exp), 64'd7);
        chk("t4_carry_inx", 64'(last_inx), 64'd1);
        send_one(48'hFFFF_FF80_0000, 10'd5, 1'b0, 3'd1);
        drain();
        chk("t4_rz_mant", 64'(last_mant), 64'hFFFFFF);
        chk("t4_rz_exp", 64'(last_exp), 64'd6);

        send_one(48'h0, 10'd77, 1'b1, 3'd5);
        drain();
        chk("zero_mant", 64'(last_mant), 64'd0);
        chk("zero_exp", 64'(last_exp), 64'd77);
        chk("zero_inx", 64'(last_inx), 64'd0);

        // Stall: two buffered, third refused, outputs held until downstream frees up.
        bus.out_ready = 1'b0;
        send_one(48'hC000_0000_1234, 10'd10, 1'b0, 3'd2);
        send_one(48'h5555_5555_5555, 10'd11, 1'b1, 3'd3);
        bus.in_valid   = 1'b1;
        bus.p          = 48'h8123_4567_89AB;
        bus.exp_in     = 10'd12;
        bus.sign_in    = 1'b0;
        bus.round_mode = 3'd0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_in_ready", 64'(bus.in_ready), 64'd0);
            chk("t5_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("t5_hold_mant", 64'(bus.mant_out), 64'(q[0].mant));
            tick();
        end
        chk("t5_buffered", 64'(q.size()), 64'd2);
        bus.out_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_in_xfer && n < 10);
        chk("t5_third_accepted", 64'(last_in_xfer), 64'd1);
        drain();

        send_one(48'h0000_0100_0000, 10'd30, 1'b0, 3'd0);
        drain();
`ifdef NORM_LZC_EN
        chk("t6_mant", 64'(last_mant), 64'h800000);
        chk("t6_exp", 64'(last_exp), 64'd8);
`else
        chk("t6_mant", 64'(last_mant), 64'h000002);
        chk("t6_exp", 64'(last_exp), 64'd30);
`endif

        // Reset with both stages full drops everything in flight.
        bus.out_ready = 1'b0;
        send_one(48'h9999_0000_0001, 10'd40, 1'b1, 3'd0);
        send_one(48'hA5A5_A5A5_A5A5, 10'd41, 1'b0, 3'd0);
        tick();
        chk("t6_full_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_mant", 64'(bus.mant_out), 64'd0);
        q.delete();
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_stale", 64'(bus.out_valid), 64'd0);
        end

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            r = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0:       pr = r[47:0];
                1:       pr = {1'b0, r[46:0]};
                2:       pr = r[47:0] >> $urandom_range(1, 47);
                default: pr = {24'hFFFFFF, r[23:0]};
            endcase
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.p          = pr;
            bus.exp_in     = 10'($urandom_range(0, 1023));
            bus.sign_in    = 1'($urandom_range(0, 1));
            bus.round_mode = 3'($urandom_range(0, 7));
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
